// File: rtl/seq_alu.sv
// seq_alu: single-cycle ALU with a valid/ready result register and an optional
// iterative MULTU/DIVU unit with HI/LO registers, enabled by macro SEQ_ALU_MULDIV_EN.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,
                         OP_SUBU = 5'd3,  OP_AND  = 5'd4,  OP_OR   = 5'd5,
                         OP_XOR  = 5'd6,  OP_NOR  = 5'd7,  OP_SLT  = 5'd8,
                         OP_SLTU = 5'd9,  OP_SLL  = 5'd10, OP_SRL  = 5'd11,
                         OP_SRA  = 5'd12;

`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [4:0] OP_MULTU = 5'd13, OP_DIVU = 5'd14,
                         OP_MFHI  = 5'd15, OP_MFLO = 5'd16;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [2:0]       r_flags, w_flags_nxt;
  logic             r_out_valid, w_valid_nxt;

  logic             w_accept, w_start_seq, w_alu_load;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum, w_diff, w_alu_res;
  logic             w_alu_ovf;

`ifdef SEQ_ALU_MULDIV_EN
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt, r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_wh, w_wh_nxt, r_wl, w_wl_nxt, r_opnd, w_opnd_nxt;
  logic [WIDTH:0]   w_mul_sum, w_div_trial;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo, w_div_hi, w_div_lo, w_seq_hi, w_seq_lo;
`endif

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

`ifdef SEQ_ALU_MULDIV_EN
  assign w_start_seq = (op == OP_MULTU) || ((op == OP_DIVU) && (b != '0));
`else
  assign w_start_seq = 1'b0;
`endif
  assign w_alu_load = w_accept && !w_start_seq;

  assign w_shamt = b[SHW-1:0];
  assign w_sum   = a + b;
  assign w_diff  = a - b;

  // Single-cycle operations; unknown codes fall through to result 0.
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: w_alu_res = w_sum;
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUBU: w_alu_res = w_diff;
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_NOR:  w_alu_res = ~(a | b);
      OP_SLT:  w_alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: w_alu_res = WIDTH'(a < b);
      OP_SLL:  w_alu_res = a << w_shamt;
      OP_SRL:  w_alu_res = a >> w_shamt;
      OP_SRA:  w_alu_res = $unsigned($signed(a) >>> w_shamt);
`ifdef SEQ_ALU_MULDIV_EN
      // Only reached for a zero divisor; nonzero divisors go iterative.
      OP_DIVU: begin
        w_alu_res = '1;
        w_alu_ovf = 1'b1;
      end
      OP_MFHI: w_alu_res = r_hi;
      OP_MFLO: w_alu_res = r_lo;
`endif
      default: ;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // One shift-add step: conditionally add multiplicand, shift {hi,lo} right.
  assign w_mul_sum = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_wl[WIDTH-1:1]};

  // One restoring step: shift dividend MSB into remainder, trial subtract.
  assign w_div_trial = {r_wh, r_wl[WIDTH-1]} - {1'b0, r_opnd};
  assign w_div_hi    = w_div_trial[WIDTH] ? {r_wh[WIDTH-2:0], r_wl[WIDTH-1]}
                                          : w_div_trial[WIDTH-1:0];
  assign w_div_lo    = {r_wl[WIDTH-2:0], ~w_div_trial[WIDTH]};

  assign w_seq_hi = (r_state == S_MUL) ? w_mul_hi : w_div_hi;
  assign w_seq_lo = (r_state == S_MUL) ? w_mul_lo : w_div_lo;
`endif

  // Next-state and output-register logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_flags_nxt  = r_flags;
    w_valid_nxt  = r_out_valid && !out_ready;
`ifdef SEQ_ALU_MULDIV_EN
    w_cnt_nxt  = r_cnt;
    w_hi_nxt   = r_hi;
    w_lo_nxt   = r_lo;
    w_wh_nxt   = r_wh;
    w_wl_nxt   = r_wl;
    w_opnd_nxt = r_opnd;
`endif

    if (w_alu_load) begin
      w_result_nxt = w_alu_res;
      w_flags_nxt  = {w_alu_res[WIDTH-1], w_alu_ovf, (w_alu_res == '0)};
      w_valid_nxt  = 1'b1;
    end

`ifdef SEQ_ALU_MULDIV_EN
    if (w_alu_load && (op == OP_DIVU)) begin
      w_hi_nxt = a;
      w_lo_nxt = '1;
    end

    if (w_accept && w_start_seq) begin
      w_state_nxt = (op == OP_MULTU) ? S_MUL : S_DIV;
      w_cnt_nxt   = WIDTH'(WIDTH - 1);
      w_wh_nxt    = '0;
      w_wl_nxt    = (op == OP_MULTU) ? b : a;
      w_opnd_nxt  = (op == OP_MULTU) ? a : b;
    end

    if (r_state != S_IDLE) begin
      w_wh_nxt = w_seq_hi;
      w_wl_nxt = w_seq_lo;
      if (r_cnt == '0) begin
        w_state_nxt  = S_IDLE;
        w_hi_nxt     = w_seq_hi;
        w_lo_nxt     = w_seq_lo;
        w_result_nxt = w_seq_lo;
        w_flags_nxt  = {w_seq_lo[WIDTH-1], 1'b0, (w_seq_lo == '0)};
        w_valid_nxt  = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - WIDTH'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_wh   <= '0;
      r_wl   <= '0;
      r_opnd <= '0;
`endif
    end else begin
      r_result    <= w_result_nxt;
      r_flags     <= w_flags_nxt;
      r_out_valid <= w_valid_nxt;
`ifdef SEQ_ALU_MULDIV_EN
      r_cnt  <= w_cnt_nxt;
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
      r_wh   <= w_wh_nxt;
      r_wl   <= w_wl_nxt;
      r_opnd <= w_opnd_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32); MULTU/DIVU checks follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu;

  localparam int unsigned W = 32;

  localparam logic [4:0] OP_ADD = 5'd0, OP_ADDU = 5'd1, OP_SUB = 5'd2, OP_SUBU = 5'd3,
                         OP_AND = 5'd4, OP_OR = 5'd5, OP_XOR = 5'd6, OP_NOR = 5'd7,
                         OP_SLT = 5'd8, OP_SLTU = 5'd9, OP_SLL = 5'd10, OP_SRL = 5'd11,
                         OP_SRA = 5'd12, OP_MULTU = 5'd13, OP_DIVU = 5'd14,
                         OP_MFHI = 5'd15, OP_MFLO = 5'd16;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [2:0]   fl;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [2:0]   flags;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  // Present one operation for exactly one edge, then drop in_valid.
  task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== '0 || flags !== 3'b000) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b result=%h flags=%b, want 0/00000000/000", out_valid, result, flags);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow;
    out_ready = 1'b1;
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 32'h8000_0000 || flags !== 3'b110) begin
      n_err++;
      $display("FAIL add_overflow: valid=%b result=%h flags=%b, want 1/80000000/110", out_valid, result, flags);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_valid_clear: got %b want 0", out_valid);
    end
  endtask

  task automatic test_ops;
    vec_t tv [0:14];
    tv = '{
      '{OP_ADD,  32'h5,         32'h3,         32'h8,         3'b000},
      '{OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         3'b001},
      '{OP_ADDU, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 3'b100},
      '{OP_SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 3'b010},
      '{OP_SUB,  32'h3,         32'h5,         32'hFFFF_FFFE, 3'b100},
      '{OP_SUBU, 32'h0,         32'h1,         32'hFFFF_FFFF, 3'b100},
      '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'b100},
      '{OP_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 3'b000},
      '{OP_XOR,  32'hAAAA_5555, 32'hAAAA_5555, 32'h0,         3'b001},
      '{OP_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF, 3'b100},
      '{OP_SLT,  32'h5,         32'hFFFF_FFFF, 32'h0,         3'b001},
      '{OP_SLTU, 32'h5,         32'hFFFF_FFFF, 32'h1,         3'b000},
      '{OP_SLL,  32'h1,         32'h3F,        32'h8000_0000, 3'b100},
      '{OP_SRL,  32'h8000_0000, 32'h4,         32'h0800_0000, 3'b000},
      '{OP_SRA,  32'h4000_0000, 32'h1,         32'h2000_0000, 3'b000}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      issue(tv[i].op, tv[i].a, tv[i].b);
      n_cmp++;
      if (out_valid !== 1'b1 || result !== tv[i].res) begin
        n_err++;
        $display("FAIL op_result[%0d] op=%0d: valid=%b result=%h, want 1/%h", i, tv[i].op, out_valid, result, tv[i].res);
      end
      n_cmp++;
      if (flags !== tv[i].fl) begin
        n_err++;
        $display("FAIL op_flags[%0d] op=%0d: flags=%b want %b", i, tv[i].op, flags, tv[i].fl);
      end
    end
  endtask

  task automatic test_illegal;
    logic [4:0] ops [$];
    ops = '{5'd17, 5'd31};
`ifndef SEQ_ALU_MULDIV_EN
    ops.push_back(OP_MULTU);
    ops.push_back(OP_DIVU);
    ops.push_back(OP_MFHI);
    ops.push_back(OP_MFLO);
`endif
    out_ready = 1'b1;
    foreach (ops[i]) begin
      issue(ops[i], 32'h1234_5678, 32'h1);
      n_cmp++;
      if (out_valid !== 1'b1 || result !== '0 || flags !== 3'b001) begin
        n_err++;
        $display("FAIL illegal_op %0d: valid=%b result=%h flags=%b, want 1/00000000/001", ops[i], out_valid, result, flags);
      end
    end
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    issue(OP_SUBU, 32'h5, 32'h5);
    in_valid = 1'b1; op = OP_ADD; a = 32'h1; b = 32'h1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || result !== '0 || flags !== 3'b001 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: valid=%b result=%h flags=%b in_ready=%b, want 1/00000000/001/0", c, out_valid, result, flags, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    in_valid = 1'b1; op = OP_SRA; a = 32'h8000_0000; b = 32'h24;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 32'hF800_0000 || flags !== 3'b100 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_sra: valid=%b result=%h flags=%b in_ready=%b, want 1/f8000000/100/1", out_valid, result, flags, in_ready);
    end
    op = OP_SLT; a = 32'hFFFF_FFFF; b = 32'h0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 32'h1 || flags !== 3'b000) begin
      n_err++;
      $display("FAIL b2b_slt: valid=%b result=%h flags=%b, want 1/00000001/000", out_valid, result, flags);
    end
    @(posedge clk); #1;
  endtask

`ifdef SEQ_ALU_MULDIV_EN
  task automatic test_muldiv;
    int cyc;
    out_ready = 1'b1;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mul_busy_ready: got %b want 0", in_ready);
    end
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    n_cmp++;
    if (cyc != 33 || result !== 32'hFFFF_FFFE || flags !== 3'b100) begin
      n_err++;
      $display("FAIL multu: latency=%0d result=%h flags=%b, want 33/fffffffe/100", cyc, result, flags);
    end
    issue(OP_MFHI, 32'h0, 32'h0);
    n_cmp++;
    if (result !== 32'h1 || flags !== 3'b000) begin
      n_err++;
      $display("FAIL mfhi_mul: result=%h flags=%b, want 00000001/000", result, flags);
    end
    issue(OP_MFLO, 32'h0, 32'h0);
    n_cmp++;
    if (result !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL mflo_mul: result=%h want fffffffe", result);
    end
    issue(OP_DIVU, 32'd100, 32'h0);
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFF || flags !== 3'b110) begin
      n_err++;
      $display("FAIL divu_zero: valid=%b result=%h flags=%b, want 1/ffffffff/110", out_valid, result, flags);
    end
    issue(OP_MFHI, 32'h0, 32'h0);
    n_cmp++;
    if (result !== 32'd100) begin
      n_err++;
      $display("FAIL mfhi_div0: result=%h want 00000064", result);
    end
    issue(OP_DIVU, 32'd100, 32'd7);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    n_cmp++;
    if (cyc != 33 || result !== 32'd14 || flags !== 3'b000) begin
      n_err++;
      $display("FAIL divu: latency=%0d result=%h flags=%b, want 33/0000000e/000", cyc, result, flags);
    end
    issue(OP_MFHI, 32'h0, 32'h0);
    n_cmp++;
    if (result !== 32'd2) begin
      n_err++;
      $display("FAIL mfhi_rem: result=%h want 00000002", result);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_mid_reset;
    bit seen;
    out_ready = 1'b0;
    issue(OP_ADD, 32'h2, 32'h3);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== '0 || flags !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset: valid=%b result=%h flags=%b, want 0/00000000/000", out_valid, result, flags);
    end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
`ifdef SEQ_ALU_MULDIV_EN
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_result: out_valid seen=%b want 0", seen);
    end
    issue(OP_MFLO, 32'h0, 32'h0);
    n_cmp++;
    if (result !== '0 || flags !== 3'b001) begin
      n_err++;
      $display("FAIL abort_mflo: result=%h flags=%b, want 00000000/001", result, flags);
    end
    issue(OP_MFHI, 32'h0, 32'h0);
    n_cmp++;
    if (result !== '0) begin
      n_err++;
      $display("FAIL abort_mfhi: result=%h want 00000000", result);
    end
`else
    seen = 1'b0;
    issue(OP_SUB, 32'h9, 32'h2);
    if (out_valid !== 1'b1) seen = 1'b1;
    n_cmp++;
    if (seen !== 1'b0 || result !== 32'h7) begin
      n_err++;
      $display("FAIL post_reset_op: valid=%b result=%h, want 1/00000007", out_valid, result);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_overflow();
    test_ops();
    test_illegal();
    test_hold();
    test_back_to_back();
`ifdef SEQ_ALU_MULDIV_EN
    test_muldiv();
`endif
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
